sx_recv: RTL and testbench

SX_RECV -- requirements
Module: sx_recv

---
 rtl/sx_recv.sv | 194 +++++++++++++++++++
 tb/tb_sx_recv.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sx_recv.sv
// sx_recv: parses FF / slot / LEN payload / AA / 55 frames into a local buffer,
// then drains the payload into the channel FIFO selected by the slot maps.
module sx_recv #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int BUF_DEPTH   = 512
) (
  input  logic        sys_clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] ctrl_timeslot,
  input  logic [31:0] busi_timeslot,
  input  logic [31:0] circuit_timeslot,
  input  logic [7:0]  down_gear,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [2:0]  recv_fifo_wr_en,
  output logic [7:0]  recv_fifo_wr_data,
  input  logic [2:0]  recv_fifo_full_i,
  output logic        frame_done_o,
  output logic        frame_err_o,
  output logic [2:0]  err_code_o,
  output logic [4:0]  frame_slot_o,
  output logic [15:0] frame_ok_cnt_o,
  output logic [15:0] frame_err_cnt_o
);

  localparam int PW = 9;
  localparam int TW = $clog2(TIMEOUT_CYC + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_SLOT, S_PAYLOAD, S_TAIL_AA, S_TAIL_55, S_DRAIN
  } state_e;

  typedef enum logic [2:0] {
    E_NONE = 3'd0, E_SLOT = 3'd1, E_TAIL_AA = 3'd2,
    E_TAIL_55 = 3'd3, E_TIMEOUT = 3'd4, E_OVERRUN = 3'd5
  } err_e;

  function automatic logic [PW-1:0] gear_len(input logic [7:0] gear);
    case (gear)
      8'hCA:        gear_len = 9'd10;
      8'hC7:        gear_len = 9'd20;
      8'hC6, 8'hC5: gear_len = 9'd40;
      8'hC4, 8'hC3: gear_len = 9'd80;
      8'hC2, 8'hC1: gear_len = 9'd160;
      8'hC0:        gear_len = 9'd320;
      default:      gear_len = 9'd0;
    endcase
  endfunction

  state_e          r_state;
  err_e            r_err_code;
  logic [PW-1:0]   r_len;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [2:0]      r_ch;
  logic [4:0]      r_slot;
  logic [4:0]      r_frame_slot;
  logic [TW-1:0]   r_idle_cnt;
  logic            r_done;
  logic            r_err;
  logic [15:0]     r_ok_cnt;
  logic [15:0]     r_err_cnt;
  logic [7:0]      r_buf [BUF_DEPTH];

  logic [PW-1:0]   w_gear_len;
  logic [2:0]      w_slot_hits;
  logic            w_slot_ok;
  logic            w_in_frame;
  logic            w_timeout;
  logic            w_abort;
  err_e            w_abort_code;
  logic            w_fire;
  logic            w_buf_we;

  assign w_gear_len  = gear_len(down_gear);
  assign w_slot_hits = {circuit_timeslot[rx_data_i[4:0]],
                        busi_timeslot[rx_data_i[4:0]],
                        ctrl_timeslot[rx_data_i[4:0]]};
  assign w_slot_ok   = (rx_data_i[7:5] == 3'b000) && $onehot(w_slot_hits);
  assign w_in_frame  = (r_state == S_SLOT) || (r_state == S_PAYLOAD) ||
                       (r_state == S_TAIL_AA) || (r_state == S_TAIL_55);
  // Fires on the idle cycle that follows TIMEOUT_CYC idle cycles already counted.
  assign w_timeout   = w_in_frame && !rx_valid_i && (r_idle_cnt == TW'(TIMEOUT_CYC));
  assign w_buf_we    = (r_state == S_PAYLOAD) && rx_valid_i;

  assign recv_fifo_wr_en   = (r_state == S_DRAIN) ? (r_ch & ~recv_fifo_full_i) : 3'b000;
  assign recv_fifo_wr_data = (r_state == S_DRAIN) ? r_buf[r_rd_ptr] : 8'h00;
  assign w_fire            = |recv_fifo_wr_en;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_abort      = 1'b0;
    w_abort_code = E_NONE;
    if (w_timeout) begin
      w_abort      = 1'b1;
      w_abort_code = E_TIMEOUT;
    end else if (rx_valid_i) begin
      case (r_state)
        S_SLOT:    if (!w_slot_ok)          begin w_abort = 1'b1; w_abort_code = E_SLOT;    end
        S_TAIL_AA: if (rx_data_i != 8'hAA)  begin w_abort = 1'b1; w_abort_code = E_TAIL_AA; end
        S_TAIL_55: if (rx_data_i != 8'h55)  begin w_abort = 1'b1; w_abort_code = E_TAIL_55; end
        default:   ;
      endcase
    end
  end

  // NOTE: the payload memory is deliberately left unreset; pointers and state
  // gate every read, so clearing it would cost logic and buy nothing.
  always_ff @(posedge sys_clk_i) begin
    if (w_buf_we) r_buf[r_wr_ptr] <= rx_data_i;
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_err_code   <= E_NONE;
      r_len        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_ch         <= '0;
      r_slot       <= '0;
      r_frame_slot <= '0;
      r_idle_cnt   <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_ok_cnt     <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      if (w_in_frame && !rx_valid_i) r_idle_cnt <= r_idle_cnt + 1'b1;
      else                           r_idle_cnt <= '0;

      if (w_abort) begin
        r_state    <= S_IDLE;
        r_err      <= 1'b1;
        r_err_code <= w_abort_code;
        r_err_cnt  <= r_err_cnt + 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (rx_valid_i && rx_data_i == 8'hFF && w_gear_len != '0) begin
              r_len    <= w_gear_len;
              r_wr_ptr <= '0;
              r_rd_ptr <= '0;
              r_state  <= S_SLOT;
            end
          end
          S_SLOT: begin
            if (rx_valid_i) begin
              r_ch    <= w_slot_hits;
              r_slot  <= rx_data_i[4:0];
              r_state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            if (rx_valid_i) begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              if (r_wr_ptr == r_len - 9'd1) r_state <= S_TAIL_AA;
            end
          end
          S_TAIL_AA: if (rx_valid_i) r_state <= S_TAIL_55;
          S_TAIL_55: if (rx_valid_i) r_state <= S_DRAIN;
          S_DRAIN: begin
            // A new header arriving while draining is an overrun: count it, drop it.
            if (rx_valid_i && rx_data_i == 8'hFF) begin
              r_err_code <= E_OVERRUN;
              r_err_cnt  <= r_err_cnt + 1'b1;
            end
            if (w_fire) begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
              if (r_rd_ptr == r_len - 9'd1) begin
                r_state      <= S_IDLE;
                r_done       <= 1'b1;
                r_frame_slot <= r_slot;
                r_ok_cnt     <= r_ok_cnt + 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign frame_done_o    = r_done;
  assign frame_err_o     = r_err;
  assign err_code_o      = r_err_code;
  assign frame_slot_o    = r_frame_slot;
  assign frame_ok_cnt_o  = r_ok_cnt;
  assign frame_err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_sx_recv.sv
// Self-checking bench for sx_recv: payload bytes are queued as they are sent
// and popped by a write monitor; per-scenario tasks check pulses and counters.
module tb_sx_recv;

  localparam int TIMEOUT_CYC = 1024;

  logic        sys_clk_i = 1'b0;
  logic        rst_n_i   = 1'b0;
  logic [31:0] ctrl_timeslot    = '0;
  logic [31:0] busi_timeslot    = '0;
  logic [31:0] circuit_timeslot = '0;
  logic [7:0]  down_gear  = 8'h00;
  logic [7:0]  rx_data_i  = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic [2:0]  recv_fifo_full_i = 3'b000;
  logic [2:0]  recv_fifo_wr_en;
  logic [7:0]  recv_fifo_wr_data;
  logic        frame_done_o;
  logic        frame_err_o;
  logic [2:0]  err_code_o;
  logic [4:0]  frame_slot_o;
  logic [15:0] frame_ok_cnt_o;
  logic [15:0] frame_err_cnt_o;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_writes = 0;
  int         exp_ok   = 0;
  int         exp_err  = 0;
  logic [7:0] exp_q [$];
  logic [2:0] exp_ch   = 3'b000;
  logic [7:0] mon_exp;

  sx_recv #(.TIMEOUT_CYC(TIMEOUT_CYC), .BUF_DEPTH(512)) dut (
    .sys_clk_i        (sys_clk_i),
    .rst_n_i          (rst_n_i),
    .ctrl_timeslot    (ctrl_timeslot),
    .busi_timeslot    (busi_timeslot),
    .circuit_timeslot (circuit_timeslot),
    .down_gear        (down_gear),
    .rx_data_i        (rx_data_i),
    .rx_valid_i       (rx_valid_i),
    .recv_fifo_wr_en  (recv_fifo_wr_en),
    .recv_fifo_wr_data(recv_fifo_wr_data),
    .recv_fifo_full_i (recv_fifo_full_i),
    .frame_done_o     (frame_done_o),
    .frame_err_o      (frame_err_o),
    .err_code_o       (err_code_o),
    .frame_slot_o     (frame_slot_o),
    .frame_ok_cnt_o   (frame_ok_cnt_o),
    .frame_err_cnt_o  (frame_err_cnt_o)
  );

  always #3 sys_clk_i = ~sys_clk_i;

  // Each mid-cycle sample with a strobe set is one FIFO write at the next edge.
  always @(negedge sys_clk_i) begin
    if (rst_n_i && recv_fifo_wr_en != 3'b000) begin
      n_writes++;
      n_checks++;
      if (recv_fifo_wr_en !== exp_ch || (recv_fifo_wr_en & recv_fifo_full_i) != 3'b000) begin
        n_errors++;
        $display("FAIL wr_en: got %b need %b (full %b)", recv_fifo_wr_en, exp_ch, recv_fifo_full_i);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got data %h, none expected", recv_fifo_wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (recv_fifo_wr_data !== mon_exp) begin
          n_errors++;
          $display("FAIL wr_data: got %h need %h", recv_fifo_wr_data, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge sys_clk_i); #1;
  endtask

  task automatic put(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    step();
  endtask

  task automatic gap(input int n);
    rx_valid_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_frame(input logic [7:0] slot_b, input int len,
                            input logic [7:0] tail2, input bit good);
    put(8'hFF);
    put(slot_b);
    for (int i = 0; i < len; i++) begin
      if (good) exp_q.push_back(8'(i));
      put(8'(i));
    end
    put(8'hAA);
    put(tail2);
    rx_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [4:0] slot);
    bit got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge sys_clk_i);
      if (frame_done_o) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL %s_done: no frame_done_o pulse within 2000 cycles", name);
    end else begin
      exp_ok++;
      n_checks++;
      if (frame_ok_cnt_o !== 16'(exp_ok)) begin
        n_errors++;
        $display("FAIL %s_ok_cnt: got %0d need %0d", name, frame_ok_cnt_o, exp_ok);
      end
      n_checks++;
      if (frame_slot_o !== slot) begin
        n_errors++;
        $display("FAIL %s_slot: got %0d need %0d", name, frame_slot_o, slot);
      end
    end
    n_checks++;
    if (frame_err_cnt_o !== 16'(exp_err) || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: err_cnt %0d need %0d, %0d bytes undelivered",
               name, frame_err_cnt_o, exp_err, exp_q.size());
    end
    step();
  endtask

  task automatic wait_err(input string name, input logic [2:0] code,
                          input int budget, output int cyc);
    bit got = 1'b0;
    cyc = -1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge sys_clk_i);
      if (frame_err_o) begin got = 1'b1; cyc = i; end
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL %s_err: no frame_err_o pulse within %0d cycles", name, budget);
    end else begin
      exp_err++;
      n_checks++;
      if (err_code_o !== code || frame_err_cnt_o !== 16'(exp_err)) begin
        n_errors++;
        $display("FAIL %s_code: got code %0d cnt %0d need code %0d cnt %0d",
                 name, err_code_o, frame_err_cnt_o, code, exp_err);
      end
    end
    step();
  endtask

  task automatic check_outputs_zero(input string name);
    n_checks++;
    if ({recv_fifo_wr_en, recv_fifo_wr_data, frame_done_o, frame_err_o, err_code_o,
         frame_slot_o, frame_ok_cnt_o, frame_err_cnt_o} !== '0) begin
      n_errors++;
      $display("FAIL %s: outputs not zero (wr_en %b data %h done %b err %b code %0d slot %0d ok %0d errcnt %0d)",
               name, recv_fifo_wr_en, recv_fifo_wr_data, frame_done_o, frame_err_o,
               err_code_o, frame_slot_o, frame_ok_cnt_o, frame_err_cnt_o);
    end
  endtask

  task automatic use_ctrl_slot3();
    ctrl_timeslot = 32'h0000_0008; busi_timeslot = '0; circuit_timeslot = '0;
    exp_ch = 3'b001;
  endtask

  task automatic test_reset();
    #1;
    check_outputs_zero("reset_state");
    repeat (2) step();
    rst_n_i = 1'b1;
    step();
    check_outputs_zero("after_release");
  endtask

  task automatic test_good();
    down_gear = 8'hC7;
    use_ctrl_slot3();
    send_frame(8'h03, 20, 8'h55, 1'b1);
    wait_done("good", 5'd3);
  endtask

  task automatic test_bad_tail();
    int cyc;
    int w0 = n_writes;
    send_frame(8'h03, 20, 8'h54, 1'b0);
    wait_err("bad_tail", 3'd3, 50, cyc);
    gap(25);
    n_checks++;
    if (n_writes != w0) begin
      n_errors++;
      $display("FAIL bad_tail_writes: got %0d need 0", n_writes - w0);
    end
  endtask

  task automatic test_backpressure();
    int w0 = n_writes;
    down_gear = 8'hCA;
    ctrl_timeslot = '0; busi_timeslot = 32'h0000_0080; circuit_timeslot = '0;
    exp_ch = 3'b010;
    send_frame(8'h07, 10, 8'h55, 1'b1);
    step(); step();
    recv_fifo_full_i = 3'b010;
    repeat (5) step();
    recv_fifo_full_i = 3'b000;
    wait_done("backpressure", 5'd7);
    n_checks++;
    if (n_writes - w0 != 10) begin
      n_errors++;
      $display("FAIL backpressure_count: got %0d writes need 10", n_writes - w0);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    down_gear = 8'hC7;
    use_ctrl_slot3();
    put(8'hFF); put(8'h03);
    for (int i = 0; i < 5; i++) put(8'(i));
    rx_valid_i = 1'b0;
    wait_err("timeout", 3'd4, TIMEOUT_CYC + 50, cyc);
    n_checks++;
    if (cyc != TIMEOUT_CYC + 1) begin
      n_errors++;
      $display("FAIL timeout_latency: pulse after %0d idle cycles need %0d", cyc, TIMEOUT_CYC + 1);
    end
    send_frame(8'h03, 20, 8'h55, 1'b1);
    wait_done("after_timeout", 5'd3);
  endtask

  task automatic test_bad_slot();
    int cyc;
    int w0 = n_writes;
    ctrl_timeslot = 32'h0000_0200; busi_timeslot = 32'h0000_0200; circuit_timeslot = '0;
    put(8'hFF); put(8'h09);
    rx_valid_i = 1'b0;
    wait_err("bad_slot", 3'd1, 20, cyc);
    gap(5);
    n_checks++;
    if (n_writes != w0) begin
      n_errors++;
      $display("FAIL bad_slot_writes: got %0d need 0", n_writes - w0);
    end
  endtask

  task automatic test_overrun();
    use_ctrl_slot3();
    send_frame(8'h03, 20, 8'h55, 1'b1);
    recv_fifo_full_i = 3'b001;
    put(8'hFF);
    rx_valid_i = 1'b0;
    exp_err++;
    n_checks++;
    if (err_code_o !== 3'd5 || frame_err_cnt_o !== 16'(exp_err)) begin
      n_errors++;
      $display("FAIL overrun: got code %0d cnt %0d need code 5 cnt %0d",
               err_code_o, frame_err_cnt_o, exp_err);
    end
    repeat (3) step();
    recv_fifo_full_i = 3'b000;
    wait_done("overrun", 5'd3);
  endtask

  task automatic test_zero_len();
    int w0 = n_writes;
    down_gear = 8'h11;
    send_frame(8'h03, 20, 8'h55, 1'b0);
    gap(30);
    n_checks++;
    if (n_writes != w0 || frame_ok_cnt_o !== 16'(exp_ok) || frame_err_cnt_o !== 16'(exp_err)) begin
      n_errors++;
      $display("FAIL zero_len: writes %0d ok %0d errcnt %0d need 0 %0d %0d",
               n_writes - w0, frame_ok_cnt_o, frame_err_cnt_o, exp_ok, exp_err);
    end
  endtask

  task automatic test_max_len();
    int w0 = n_writes;
    down_gear = 8'hC0;
    use_ctrl_slot3();
    send_frame(8'h03, 320, 8'h55, 1'b1);
    wait_done("max_len", 5'd3);
    n_checks++;
    if (n_writes - w0 != 320) begin
      n_errors++;
      $display("FAIL max_len_count: got %0d writes need 320", n_writes - w0);
    end
  endtask

  task automatic test_reset_mid();
    down_gear = 8'hC7;
    use_ctrl_slot3();
    put(8'hFF); put(8'h03);
    for (int i = 0; i < 5; i++) put(8'hE0 + 8'(i));
    rst_n_i = 1'b0;
    #1;
    check_outputs_zero("reset_mid_async");
    for (int i = 0; i < 3; i++) put(8'hE5 + 8'(i));
    rx_valid_i = 1'b0;
    check_outputs_zero("reset_mid_held");
    rst_n_i = 1'b1;
    exp_ok  = 0;
    exp_err = 0;
    step();
    send_frame(8'h03, 20, 8'h55, 1'b1);
    wait_done("after_reset", 5'd3);
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_tail();
    test_backpressure();
    test_timeout();
    test_bad_slot();
    test_overrun();
    test_zero_len();
    test_max_len();
    test_reset_mid();
    gap(5);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
